// File: rtl/core_input_sched_if.sv
// Handshake bundle between the input scheduler, the realign stage and core_input.
// master drives thread requests and stage status; slave is the scheduler.
interface core_input_sched_if #(
    parameter int unsigned N_THREADS = 12,
    parameter int unsigned BLK_OP_W  = 4
);
    localparam int unsigned TN_W = $clog2(N_THREADS);

    logic [N_THREADS-1:0]          rq;
    logic [N_THREADS*BLK_OP_W-1:0] rq_blk_op;
    logic [N_THREADS-1:0]          slot_free;
    logic                          src_empty;
    logic                          set_input_ready;
    logic [TN_W-1:0]               thread_num;
    logic [BLK_OP_W-1:0]           blk_op;
    logic [N_THREADS-1:0]          grant;
    logic                          src_rd_en;
    logic                          busy;
    logic                          err_timeout;

    modport master (
        output rq, rq_blk_op, slot_free, src_empty, set_input_ready,
        input  thread_num, blk_op, grant, src_rd_en, busy, err_timeout
    );

    modport slave (
        input  rq, rq_blk_op, slot_free, src_empty, set_input_ready,
        output thread_num, blk_op, grant, src_rd_en, busy, err_timeout
    );
endinterface

// File: rtl/core_input_sched.sv
// Round-robin scheduler loading 16-word input blocks from realign into SHA-512 thread slots.
// One grant at a time: grant, meter 16 reads, then wait for the core_input completion pulse.
module core_input_sched #(
    parameter int unsigned N_CORES      = 3,
    parameter int unsigned BLK_OP_W     = 4,
    parameter int unsigned DONE_TIMEOUT = 15
) (
    input logic               CLK,
    input logic               reset,
    core_input_sched_if.slave bus
);
    localparam int unsigned N_THREADS     = 4 * N_CORES;
    localparam int unsigned N_THREADS_MSB = $clog2(N_THREADS) - 1;
    localparam int unsigned TN_W          = N_THREADS_MSB + 1;
    localparam int unsigned WAIT_W        = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWait} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [TN_W-1:0]       r_thread_num;
    logic [BLK_OP_W-1:0]   r_blk_op;
    logic [N_THREADS-1:0]  r_grant;
    logic [TN_W-1:0]       r_rr_ptr;
    logic [3:0]            r_word_cnt;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic                  r_err;

    logic [N_THREADS-1:0]  w_eligible;
    logic [TN_W-1:0]       w_sel;
    logic                  w_found;
    logic                  w_rd_en;
    logic                  w_busy;
    logic                  w_wait_last;

    assign w_eligible  = bus.rq & bus.slot_free;
    assign w_wait_last = (r_wait_cnt == WAIT_W'(DONE_TIMEOUT - 1));

    // Circular search starting one past the last granted thread.
    always_comb begin
        logic [TN_W:0] idx;
        idx     = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= int'(N_THREADS); k++) begin
            idx = {1'b0, r_rr_ptr} + (TN_W + 1)'(k);
            if (idx >= (TN_W + 1)'(N_THREADS)) begin
                idx = idx - (TN_W + 1)'(N_THREADS);
            end
            if (!w_found && w_eligible[idx[TN_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = idx[TN_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_found) w_state_d = StLoad;
            StLoad:  if (w_rd_en && r_word_cnt == 4'hF) w_state_d = StWait;
            StWait:  if (bus.set_input_ready || w_wait_last) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_rd_en = 1'b0;
        w_busy  = 1'b1;
        case (r_state)
            StIdle:  w_busy  = 1'b0;
            StLoad:  w_rd_en = !bus.src_empty;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_thread_num <= '0;
            r_blk_op     <= '0;
            r_grant      <= '0;
            r_rr_ptr     <= TN_W'(N_THREADS - 1);
            r_word_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_grant <= '0;
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_thread_num <= w_sel;
                        r_blk_op     <= bus.rq_blk_op[w_sel*BLK_OP_W +: BLK_OP_W];
                        r_grant      <= N_THREADS'(1) << w_sel;
                        r_rr_ptr     <= w_sel;
                    end
                end
                StLoad: begin
                    if (w_rd_en) r_word_cnt <= r_word_cnt + 4'd1;
                end
                StWait: begin
                    // A completion pulse on the timeout cycle still counts as on time.
                    if (bus.set_input_ready || w_wait_last) begin
                        r_wait_cnt <= '0;
                        if (!bus.set_input_ready) r_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.thread_num  = r_thread_num;
    assign bus.blk_op      = r_blk_op;
    assign bus.grant       = r_grant;
    assign bus.src_rd_en   = w_rd_en;
    assign bus.busy        = w_busy;
    assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_core_input_sched.sv
// Directed bench for core_input_sched: grant order, read metering, stalls, timeout, reset.
module tb_core_input_sched;
    logic CLK;
    logic reset;
    int   n_vec;
    int   n_err;

    core_input_sched_if #(.N_THREADS(12), .BLK_OP_W(4)) bus ();

    core_input_sched #(.N_CORES(3), .BLK_OP_W(4), .DONE_TIMEOUT(15)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [3:0] blk_of(input int t);
        return 4'((t * 3 + 1) & 15);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered on the grant cycle; leaves on the first WAIT cycle.
    task automatic run_load(input logic [31:0] mask, input logic stray, input int exp_cycles);
        int   reads;
        int   cyc;
        logic e;
        reads = 0;
        cyc   = 0;
        while (reads < 16 && cyc < 40) begin
            e = (cyc < 32) ? mask[cyc] : 1'b0;
            bus.src_empty       = e;
            bus.set_input_ready = stray;
            #1;
            check("rd_en", 32'(bus.src_rd_en), 32'(!e));
            if (bus.src_rd_en) reads++;
            cyc++;
            tick();
        end
        bus.src_empty       = 1'b0;
        bus.set_input_ready = 1'b0;
        check("reads", 32'(reads), 32'd16);
        check("load_cycles", 32'(cyc), 32'(exp_cycles));
        check("wait_rd_en", 32'(bus.src_rd_en), 32'd0);
    endtask

    task automatic finish_wait(input int delay);
        repeat (delay) tick();
        bus.set_input_ready = 1'b1;
        tick();
        bus.set_input_ready = 1'b0;
    endtask

    task automatic check_grant(input int t);
        check("grant", 32'(bus.grant), 32'(1) << t);
        check("thread_num", 32'(bus.thread_num), 32'(t));
        check("blk_op", 32'(bus.blk_op), 32'(blk_of(t)));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.rq = '0;
        bus.slot_free = '0;
        bus.src_empty = 1'b0;
        bus.set_input_ready = 1'b0;
        for (int i = 0; i < 12; i++) bus.rq_blk_op[i*4 +: 4] = blk_of(i);
        tick();
        tick();
        check("rst_thread", 32'(bus.thread_num), 32'd0);
        check("rst_blk_op", 32'(bus.blk_op), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_rd_en", 32'(bus.src_rd_en), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err_timeout), 32'd0);
        reset = 1'b0;
        tick();

        // Single request on thread 0, completion two cycles into WAIT.
        bus.rq = 12'h001;
        bus.slot_free = 12'hFFF;
        tick();
        check_grant(0);
        check("busy_load", 32'(bus.busy), 32'd1);
        bus.rq = '0;
        run_load(32'h0, 1'b0, 16);
        check("busy_wait", 32'(bus.busy), 32'd1);
        finish_wait(1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_grant", 32'(bus.grant), 32'd0);
        check("thread_hold", 32'(bus.thread_num), 32'd0);

        // Everyone eligible: strict rotation, wrapping back to 0.
        bus.rq = 12'hFFF;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_grant(k % 12);
            run_load(32'h0, 1'b0, 16);
            finish_wait(0);
        end
        bus.rq = '0;

        // Thread 7 has no slot, so thread 5 goes first.
        bus.rq = 12'h0A0;
        bus.slot_free = 12'h020;
        tick();
        check_grant(5);
        bus.slot_free = 12'h080;
        run_load(32'h0, 1'b0, 16);
        finish_wait(14);
        check("late_ready_err", 32'(bus.err_timeout), 32'd0);
        check("late_ready_busy", 32'(bus.busy), 32'd0);
        tick();
        check_grant(7);
        bus.rq = '0;
        run_load(32'h0000_0438, 1'b0, 20);

        // No completion pulse: 15 WAIT cycles, then the sticky error.
        repeat (14) tick();
        check("to_busy_pre", 32'(bus.busy), 32'd1);
        check("to_err_pre", 32'(bus.err_timeout), 32'd0);
        tick();
        check("to_err", 32'(bus.err_timeout), 32'd1);
        check("to_busy", 32'(bus.busy), 32'd0);
        bus.set_input_ready = 1'b1;
        tick();
        bus.set_input_ready = 1'b0;
        check("stray_idle", 32'(bus.busy), 32'd0);
        bus.rq = 12'h008;
        bus.slot_free = 12'hFFF;
        tick();
        check_grant(3);
        check("err_sticky", 32'(bus.err_timeout), 32'd1);
        bus.rq = '0;
        run_load(32'h0, 1'b1, 16);
        finish_wait(0);
        check("err_sticky2", 32'(bus.err_timeout), 32'd1);
        check("busy_after3", 32'(bus.busy), 32'd0);

        // Reset after the 7th read abandons the block.
        bus.rq = 12'h002;
        tick();
        check_grant(1);
        bus.rq = '0;
        repeat (7) tick();
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("ar_thread", 32'(bus.thread_num), 32'd0);
        check("ar_blk_op", 32'(bus.blk_op), 32'd0);
        check("ar_grant", 32'(bus.grant), 32'd0);
        check("ar_rd_en", 32'(bus.src_rd_en), 32'd0);
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_err", 32'(bus.err_timeout), 32'd0);
        tick();
        reset = 1'b0;
        bus.rq = 12'h004;
        tick();
        check_grant(2);
        bus.rq = '0;
        run_load(32'h0, 1'b0, 16);
        finish_wait(0);
        check("final_busy", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/core_input_sched.md
Name: core_input_sched

Overview:
- Schedules loading of 16-word (64-bit word) input blocks from the realign stage into SHA-512 core thread slots.
- Each thread has a block-pending request and a destination-slot-free flag. The scheduler grants one eligible thread at a time in round-robin order and drives the thread number and block op to the realign/core_input path.
- It meters exactly 16 word reads, then waits for the core_input completion pulse before the next grant.

Parameters:
- N_CORES, 3: number of SHA-512 cores.
- N_THREADS, 4*N_CORES: thread count. Thread number layout is {core_num, ctx_num, seq_num}.
- N_THREADS_MSB, `MSB(N_THREADS-1): MSB of the thread number.
- BLK_OP_W, `BLK_OP_MSB+1: width of one block-op field.
- DONE_TIMEOUT, 15: max cycles spent in WAIT before the error flag is set.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rq  in  N_THREADS  thread i has a pending input block.
- rq_blk_op  in  N_THREADS*BLK_OP_W  block op of thread i at bits [i*BLK_OP_W +: BLK_OP_W].
- slot_free  in  N_THREADS  core input slot for thread i can accept a block.
- src_empty  in  1  realign has no word available this cycle.
- set_input_ready  in  1  one-cycle pulse from core_input: 16th word written.
- thread_num  out  N_THREADS_MSB+1  granted thread; held stable from grant until return to IDLE.
- blk_op  out  BLK_OP_W  op of granted thread; held like thread_num.
- grant  out  N_THREADS  one-hot, 1-cycle pulse on grant.
- src_rd_en  out  1  read one word from realign.
- busy  out  1  high in any state but IDLE.
- err_timeout  out  1  sticky; cleared only by reset.

Behaviour:
- Reset values (async, immediate): state=IDLE; thread_num=0; blk_op=0; grant=0; src_rd_en=0; busy=0; err_timeout=0; word_cnt=0; rr_ptr=N_THREADS-1 (so thread 0 is searched first); wait_cnt=0.
- eligible = rq & slot_free, sampled in IDLE only.
- IDLE:
  - If eligible != 0, select the first set bit searching circularly from rr_ptr+1 (wraps N_THREADS-1 -> 0).
  - Register thread_num=sel, blk_op=rq_blk_op[sel], grant=(1<<sel) for exactly one cycle, rr_ptr=sel. Next state LOAD.
  - Grant latency: one cycle from eligible visible to grant and thread_num valid.
- LOAD:
  - src_rd_en = !src_empty (combinational from state and src_empty). Each asserted cycle counts one word.
  - word_cnt is 4-bit and increments per read. The read made with word_cnt==15 is the last; word_cnt wraps to 0 and state goes WAIT.
  - src_empty stalls the count indefinitely; no timeout in LOAD.
  - Exactly 16 src_rd_en cycles occur per grant.
- WAIT:
  - src_rd_en=0. wait_cnt increments each cycle.
  - On set_input_ready: go IDLE, wait_cnt=0. A new grant is possible on the following cycle at the earliest.
  - If wait_cnt reaches DONE_TIMEOUT without set_input_ready: set err_timeout, go IDLE, wait_cnt=0.
- Stray set_input_ready in IDLE or LOAD is ignored. A set_input_ready arriving in the same cycle as the timeout wins (no error).
- rq or slot_free deasserting after grant does not abort the transfer.
- thread_num and blk_op change only on a grant cycle.
- Round-robin fairness: a continuously eligible thread is granted within N_THREADS grants.
- Reset mid-LOAD or mid-WAIT returns to IDLE immediately. The partial block is abandoned; the upstream flush is handled elsewhere.

Test Plan:
- Reset, then rq=12'h001, slot_free=all, src_empty=0 -> grant=12'h001 one cycle later, thread_num=0; src_rd_en high for 16 consecutive cycles; set_input_ready 2 cycles later -> IDLE, busy=0.
- rq=all ones, slot_free=all ones, set_input_ready returned promptly each time -> grant order 0,1,2,...,11,0.
- rq=12'h0A0 with slot_free=12'h020 -> thread 5 granted and thread 7 skipped. Then slot_free=12'h080 -> thread 7 granted.
- During LOAD, src_empty high on words 3-5 and 10 -> src_rd_en low on exactly those cycles; total reads still 16; LOAD lasts 20 cycles.
- No set_input_ready after the 16th read -> err_timeout=1 after 15 WAIT cycles, state IDLE, next grant still issued; err_timeout stays 1.
- reset asserted after the 7th read -> all outputs at reset values in the same cycle; after release, rq=12'h004 -> fresh 16-read sequence for thread 2 with blk_op=rq_blk_op[2].
